uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 UART transmitter; serialises parallel bytes onto one line, LSB first.
- Sits directly upstream of uart_rx: its `tx` output drives uart_rx `rx_input_data` in loopback and system benches.
- Byte source connects through a valid/ready handshake.
- `tx_state` mirrors the 2-bit state encoding of uart_rx `rx_state`, so both ends can be probed identically.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal minimum 2; internal counter width = $clog2(CLKS_PER_BIT).
- DATA_BITS, 8, data bits per frame; legal range 5..8; `tx_data` width is fixed at 8, unused MSBs ignored.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  source has a byte on tx_data.
- tx_ready  output  1  transmitter can accept a byte (high only in IDLE).
- tx  output  1  serial line; idles high.
- tx_state  output  2  0=IDLE, 1=START, 2=DATA, 3=STOP.
- tx_done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (RST high at a rising edge) takes effect at that edge, regardless of state:
  - tx=1, tx_ready=1, tx_state=IDLE, tx_done=0.
  - Bit counter and baud counter = 0; shift register = 0.
- Handshake:
  - Accept occurs at an edge where tx_valid=1 and tx_ready=1.
  - At that edge, tx_data is latched into the shift register; state→START, tx=0, tx_ready=0, baud counter=0.
  - tx_valid while tx_ready=0 is ignored; the source must hold it. tx_data changes while busy have no effect.
- Baud counting:
  - Every serial bit is held on tx for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- States:
  - IDLE: tx=1, tx_ready=1. On accept → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA with bit index 0.
  - DATA: tx = shift register bit 0; shift right at each bit boundary. After bit DATA_BITS-1 → STOP (→ parity first when the optional feature is enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then → IDLE, with tx_done=1 and tx_ready=1 in the first IDLE cycle.
- Latency and throughput:
  - The first start-bit cycle is the cycle immediately after the accept edge.
  - A frame occupies (2+DATA_BITS)*CLKS_PER_BIT cycles of line time.
  - Earliest next accept is at the end of the first IDLE cycle, so back-to-back frames have exactly 1 idle-high cycle between stop and start.
- tx is registered (glitch-free); tx_done is high exactly 1 cycle per completed frame.
- Reset mid-frame: the frame is aborted, tx returns high at the reset edge, and no tx_done pulse is produced.
- tx_valid asserted during reset is not accepted; acceptance is possible from the first edge with RST low.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After the last data bit, an extra PARITY state sends the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles, then → STOP.
  - Frame = (3+DATA_BITS)*CLKS_PER_BIT cycles.
  - tx_state widens to 3 bits: PARITY=4; the encodings of the other states are unchanged.
- Undefined: no parity state; tx_state is 2 bits; timing as above.

Test Plan:
- Reset: hold RST=1 for 3 cycles with tx_valid=1 → tx=1, tx_ready=1, tx_state=0, tx_done=0 throughout, and no accept.
- Single byte 0x55, CLKS_PER_BIT=4 → tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each level held 4 cycles; 40 cycles total; tx_done pulses on cycle 41.
- Back-to-back 0xA3 then 0x0F with tx_valid held high → second start bit begins exactly 1 idle cycle after the first stop bit; data bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Busy ignore: change tx_data to 0xFF mid-frame of 0x12 → line still carries 0x12; 0xFF is accepted only after the return to IDLE.
- Reset mid-frame: assert RST during DATA bit 3 → tx=1 and tx_state=0 at that edge; no tx_done pulse; the next frame transmits normally.
- UART_TX_PARITY_EN defined, send 0x07 → parity bit 1 after the data bits; 0x03 → parity bit 0; each frame is 44 cycles at CLKS_PER_BIT=4. Loopback into uart_rx recovers each byte.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (tx_state widens to 3 bits, PARITY=4).
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
`ifdef UART_TX_PARITY_EN
    output logic [2:0] tx_state,
`else
    output logic [1:0] tx_state,
`endif
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
`endif
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]    DATA_MASK = 8'(255 >> (8 - DATA_BITS));

    // Encodings match uart_rx rx_state so both ends probe identically.
    typedef enum logic [SW-1:0] {
        S_IDLE   = SW'(0),
        S_START  = SW'(1),
        S_DATA   = SW'(2),
`ifdef UART_TX_PARITY_EN
        S_STOP   = SW'(3),
        S_PARITY = SW'(4)
`else
        S_STOP   = SW'(3)
`endif
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_baud, w_baud;
    logic [2:0]      r_bitIdx, w_bitIdx;
    logic [7:0]      r_shift, w_shift;
    logic            r_tx, w_tx;
    logic            r_done, w_done;
    logic            w_baudLast;
`ifdef UART_TX_PARITY_EN
    logic            r_parity, w_parity;
`endif

    always_comb begin
        w_state    = r_state;
        w_baud     = r_baud;
        w_bitIdx   = r_bitIdx;
        w_shift    = r_shift;
        w_tx       = r_tx;
        w_done     = 1'b0;
        w_baudLast = (r_baud == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        w_parity   = r_parity;
`endif
        // Every non-idle state holds its line level for one full baud period.
        if (r_state != S_IDLE) begin
            w_baud = w_baudLast ? '0 : r_baud + 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (tx_valid) begin
                    w_state  = S_START;
                    w_shift  = tx_data & DATA_MASK;
                    w_tx     = 1'b0;
                    w_baud   = '0;
                    w_bitIdx = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity = ^(tx_data & DATA_MASK);
`endif
                end
            end
            S_START: begin
                if (w_baudLast) begin
                    w_state  = S_DATA;
                    w_bitIdx = '0;
                    w_tx     = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baudLast) begin
                    if (r_bitIdx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
                        w_tx    = r_parity;
`else
                        w_state = S_STOP;
                        w_tx    = 1'b1;
`endif
                    end else begin
                        w_bitIdx = r_bitIdx + 3'd1;
                        w_shift  = r_shift >> 1;
                        w_tx     = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baudLast) begin
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baudLast) begin
                    w_state = S_IDLE;
                    w_tx    = 1'b1;
                    w_done  = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_baud   <= w_baud;
            r_bitIdx <= w_bitIdx;
            r_shift  <= w_shift;
            r_tx     <= w_tx;
            r_done   <= w_done;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity;
`endif
        end
    end

    assign tx_ready = (r_state == S_IDLE);
    assign tx       = r_tx;
    assign tx_state = r_state;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps plus a line-decoding scoreboard.
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int SW = 3;
    localparam int NB = DB + 3;
`else
    localparam int SW = 2;
    localparam int NB = DB + 2;
`endif
    localparam int FRAME_CYC = NB * CPB;

    logic          clk = 1'b0;
    logic          RST;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic [SW-1:0] tx_state;
    logic          tx_done;

    int compared       = 0;
    int mismatched     = 0;
    int framesPushed   = 0;
    int framesComplete = 0;
    logic [7:0] expQ[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .RST      (RST),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_state (tx_state),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic lineBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == DB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Drive a byte and wait (bounded) for the accept edge; the byte enters the scoreboard then.
    task automatic applyStimulus(input logic [7:0] d, input bit keepValid);
        bit accepted = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (tx_ready === 1'b1) begin
                expQ.push_back(d);
                framesPushed++;
                accepted = 1'b1;
            end
            tick();
        end
        checkOutput($sformatf("accept_%02h", d), 32'(accepted), 1);
        if (!keepValid) tx_valid = 1'b0;
    endtask

    // Walk a frame from cycle startC (1 = first start-bit cycle) to the tx_done cycle.
    task automatic checkFrameTiming(input string tag, input int startC);
        for (int c = startC; c <= FRAME_CYC + 1; c++) begin
            checkOutput($sformatf("%s_done_c%0d", tag, c), 32'(tx_done), 32'(c == FRAME_CYC + 1));
            checkOutput($sformatf("%s_ready_c%0d", tag, c), 32'(tx_ready), 32'(c == FRAME_CYC + 1));
            if (c == 1) checkOutput($sformatf("%s_state_start", tag), 32'(tx_state), 1);
            if (c == CPB + 1) checkOutput($sformatf("%s_state_data", tag), 32'(tx_state), 2);
`ifdef UART_TX_PARITY_EN
            if (c == FRAME_CYC - 2 * CPB + 1) checkOutput($sformatf("%s_state_parity", tag), 32'(tx_state), 4);
`endif
            if (c == FRAME_CYC - CPB + 1) checkOutput($sformatf("%s_state_stop", tag), 32'(tx_state), 3);
            if (c == FRAME_CYC + 1) begin
                checkOutput($sformatf("%s_state_idle", tag), 32'(tx_state), 0);
                checkOutput($sformatf("%s_tx_idle", tag), 32'(tx), 1);
            end else begin
                tick();
            end
        end
    endtask

    // Scoreboard: decode each frame cycle by cycle against the byte popped at its start bit.
    initial begin
        bit         monActive = 1'b0;
        int         monCnt    = 0;
        logic [7:0] monExp    = 8'h00;
        forever begin
            @(negedge clk);
            if (RST !== 1'b0) begin
                monActive = 1'b0;
            end else begin
                if (!monActive && tx === 1'b0) begin
                    checkOutput("sb_queue_has_entry", 32'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        monExp    = expQ.pop_front();
                        monActive = 1'b1;
                        monCnt    = 0;
                    end
                end
                if (monActive) begin
                    checkOutput($sformatf("sb_%02h_bit%0d_c%0d", monExp, monCnt / CPB, monCnt),
                                32'(tx), 32'(lineBit(monExp, monCnt / CPB)));
                    monCnt++;
                    if (monCnt == FRAME_CYC) begin
                        monActive = 1'b0;
                        framesComplete++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        RST      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;

        // Reset held with tx_valid high: idle outputs, no accept.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst_tx_%0d", i), 32'(tx), 1);
            checkOutput($sformatf("rst_ready_%0d", i), 32'(tx_ready), 1);
            checkOutput($sformatf("rst_state_%0d", i), 32'(tx_state), 0);
            checkOutput($sformatf("rst_done_%0d", i), 32'(tx_done), 0);
        end
        RST = 1'b0;

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55, 1'b0);
        checkOutput("s55_tx_start", 32'(tx), 0);
        checkFrameTiming("s55", 1);
        tick();
        checkOutput("s55_done_cleared", 32'(tx_done), 0);

        $display("[TB] back-to-back 0xA3, 0x0F");
        applyStimulus(8'hA3, 1'b1);
        tx_data = 8'h0F;
        checkFrameTiming("b2b_a3", 1);
        applyStimulus(8'h0F, 1'b0);
        checkFrameTiming("b2b_0f", 1);

        $display("[TB] busy ignore 0x12 then 0xFF");
        applyStimulus(8'h12, 1'b0);
        repeat (14) tick();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        checkFrameTiming("busy_12", 15);
        applyStimulus(8'hFF, 1'b0);
        checkFrameTiming("busy_ff", 1);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'h5A, 1'b0);
        repeat (17) tick();
        checkOutput("mid_state_data", 32'(tx_state), 2);
        RST = 1'b1;
        tick();
        checkOutput("mid_rst_tx", 32'(tx), 1);
        checkOutput("mid_rst_state", 32'(tx_state), 0);
        checkOutput("mid_rst_ready", 32'(tx_ready), 1);
        RST = 1'b0;
        for (int i = 0; i < FRAME_CYC + 4; i++) begin
            tick();
            checkOutput($sformatf("mid_nodone_%0d", i), 32'(tx_done), 0);
            checkOutput($sformatf("mid_idle_tx_%0d", i), 32'(tx), 1);
        end
        applyStimulus(8'hC6, 1'b0);
        checkFrameTiming("post_rst_c6", 1);

        $display("[TB] parity patterns 0x07, 0x03");
        applyStimulus(8'h07, 1'b0);
        checkFrameTiming("p07", 1);
        applyStimulus(8'h03, 1'b0);
        checkFrameTiming("p03", 1);
        repeat (3) tick();

        checkOutput("sb_queue_drained", 32'(expQ.size()), 0);
        checkOutput("sb_frames_complete", 32'(framesComplete), 32'(framesPushed - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
